if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Produces the per-cycle fetch bundle consumed by the IF/ID pipeline register: PC, PC+4, instruction, branch-prediction flags and flush request.
- Holds the architectural fetch PC and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Sequences MIPS delay slots: after a predicted-taken branch, the delay slot is fetched first, then the target.
- Accepts redirects and BTB training from the branch-resolution logic in ID/EX.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- BTB_IDX_W, $clog2(BTB_ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold PC and pending state this cycle
- Redirect_Valid  in  1  mispredict or exception redirect from ID/EX
- Redirect_Target  in  32  corrected fetch PC
- Upd_Valid  in  1  BTB training strobe for a resolved branch
- Upd_PC  in  32  PC of the resolved branch
- Upd_Target  in  32  resolved taken target
- Upd_Taken  in  1  resolved direction
- Upd_Likely  in  1  resolved branch is a branch-likely
- imem_addr  out  32  instruction memory address; equals the PC register
- imem_rdata  in  32  instruction word; combinational, same cycle
- IF_PC  out  32  current fetch PC
- IF_PC_plus_4  out  32  IF_PC + 4, modulo 2^32
- IF_Instruction  out  32  imem_rdata pass-through
- IF_Branch  out  1  predicted taken
- IF_Branch_likely  out  1  BTB entry marked likely
- IF_BTB_Hit  out  1  BTB tag hit
- IF_Flush  out  1  flush IF/ID; equals Redirect_Valid

Behaviour:
- Reset (asynchronous): PC = RESET_PC; pending = 0; pend_target = 0; all BTB valid bits = 0; counters = 2'b01.
- While in reset, outputs are: IF_PC = RESET_PC, IF_PC_plus_4 = RESET_PC+4, IF_Branch = 0, IF_BTB_Hit = 0, IF_Branch_likely = 0.
- Lookup is combinational on PC:
  - idx = PC[BTB_IDX_W+1:2]; tag = PC[31:BTB_IDX_W+2].
  - hit = valid[idx] && tag matches.
  - IF_BTB_Hit = hit; IF_Branch = hit && ctr[1]; IF_Branch_likely = hit && likely bit.
- Prediction outputs are forced to 0 while pending = 1, because the delay slot is never predicted.
- Two-state delay-slot sequencer:
  - SEQ: normal fetch.
  - PEND: the delay slot is being fetched; pend_target is held.
- Next-PC priority, evaluated at the clock edge (highest first):
  1. Redirect_Valid: PC = Redirect_Target; state = SEQ. Overrides Stall.
  2. Stall: PC, state and pend_target all hold.
  3. PEND: PC = pend_target; state = SEQ.
  4. SEQ with IF_Branch = 1: PC = PC+4; pend_target = BTB target; state = PEND.
  5. Otherwise: PC = PC+4.
- PC+4 wraps from 32'hFFFF_FFFC to 0; no trap.
- BTB training, written at the clock edge when Upd_Valid = 1:
  - Tag hit at Upd_PC: counter moves +1 if taken, -1 if not taken, saturating at 2'b11 and 2'b00. Target and likely are overwritten with Upd_Target and Upd_Likely.
  - Miss and taken: allocate the entry (overwriting any occupant). valid = 1, tag, target, likely, ctr = 2'b10.
  - Miss and not taken: no change.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update contents.
- Training is independent of Stall and Redirect_Valid; an update is never dropped.
- Redirect_Valid arriving in PEND discards pend_target.

Decomposition:
- Shared package if_pkg:
  - RESET_PC default.
  - Counter encodings: SNT = 00, WNT = 01, WT = 10, ST = 11.
  - btb_entry_t struct: valid, tag, target, ctr, likely.
  - Sequencer state enum: SEQ, PEND.
- One sub-module, if_btb. It contains the entry array, the combinational lookup port and the synchronous update port, with reset clearing. The PC, sequencer and next-PC mux stay in if_fetch_unit.

Test Plan:
- Release reset, no stall, BTB empty -> IF_PC steps BFC0_0000, BFC0_0004, BFC0_0008; IF_Branch = 0; IF_PC_plus_4 = IF_PC + 4 every cycle.
- Train Upd_PC = BFC0_0010, Upd_Target = BFC0_0100, Upd_Taken = 1, then refetch through it -> at 0010: IF_BTB_Hit = 1, IF_Branch = 1. Next cycle IF_PC = 0014 (delay slot, IF_Branch = 0), then IF_PC = 0100.
- Stall asserted for 3 cycles while in PEND at 0014 -> IF_PC holds 0014; after release IF_PC = BFC0_0100.
- Redirect_Valid = 1 to 8000_0180 together with Stall = 1 while in PEND -> next IF_PC = 8000_0180; IF_Flush = 1 that cycle; pending cleared, so no jump to 0100 follows.
- Train the same PC not-taken twice from ctr = 10 -> ctr goes 01 then 00, IF_Branch = 0. Further not-taken leaves ctr at 00. Three taken updates from 00 reach 11; a fourth stays 11.
- Assert reset mid-PEND with valid BTB entries -> IF_PC = RESET_PC immediately; the previously trained PC now gives IF_BTB_Hit = 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its
// branch target buffer.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          TAG_W_MAX        = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Tags are kept zero-extended to the widest possible tag so the struct
    // does not depend on the BTB size.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
        logic                 likely;
    } btb_entry_t;

    typedef enum logic {
        SEQ  = 1'b0,
        PEND = 1'b1
    } seq_state_t;

    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
        else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

    function automatic logic [TAG_W_MAX-1:0] pc_tag(logic [31:0] pc, int idx_w);
        return TAG_W_MAX'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer: combinational lookup port and a
// synchronous training port with 2-bit saturating direction counters.
module if_btb
    import if_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    localparam int BTB_IDX_W  = $clog2(BTB_ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        lookup_hit,
    output logic        lookup_taken,
    output logic        lookup_likely,
    output logic [31:0] lookup_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_likely
);

    btb_entry_t entries [BTB_ENTRIES];

    logic [BTB_IDX_W-1:0] rd_idx;
    btb_entry_t           rd_entry;
    logic [BTB_IDX_W-1:0] wr_idx;
    btb_entry_t           wr_entry;
    logic                 wr_hit;

    // Lookup reads the registered array, so a same-cycle update is not visible.
    assign rd_idx        = lookup_pc[BTB_IDX_W+1:2];
    assign rd_entry      = entries[rd_idx];
    assign lookup_hit    = rd_entry.valid && (rd_entry.tag == pc_tag(lookup_pc, BTB_IDX_W));
    assign lookup_taken  = rd_entry.ctr[1];
    assign lookup_likely = rd_entry.likely;
    assign lookup_target = rd_entry.target;

    assign wr_idx   = upd_pc[BTB_IDX_W+1:2];
    assign wr_entry = entries[wr_idx];
    assign wr_hit   = wr_entry.valid && (wr_entry.tag == pc_tag(upd_pc, BTB_IDX_W));

    // NOTE: the whole array sits in flops with a reset so every valid bit and
    // counter starts known; a RAM macro could not be cleared this way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT, likely: 1'b0};
            end
        end else if (upd_valid) begin
            if (wr_hit) begin
                entries[wr_idx].ctr    <= ctr_next(wr_entry.ctr, upd_taken);
                entries[wr_idx].target <= upd_target;
                entries[wr_idx].likely <= upd_likely;
            end else if (upd_taken) begin
                entries[wr_idx] <= '{valid:  1'b1,
                                     tag:    pc_tag(upd_pc, BTB_IDX_W),
                                     target: upd_target,
                                     ctr:    WT,
                                     likely: upd_likely};
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, delay-slot sequencer, next-PC selection
// and the BTB-driven prediction outputs for the IF/ID register.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,
    input  logic        Upd_Valid,
    input  logic [31:0] Upd_PC,
    input  logic [31:0] Upd_Target,
    input  logic        Upd_Taken,
    input  logic        Upd_Likely,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC_plus_4,
    output logic [31:0] IF_Instruction,
    output logic        IF_Branch,
    output logic        IF_Branch_likely,
    output logic        IF_BTB_Hit,
    output logic        IF_Flush
);

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        btb_hit;
    logic        btb_taken;
    logic        btb_likely;
    logic [31:0] btb_target;

    if_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .reset        (reset),
        .lookup_pc    (pc_q),
        .lookup_hit   (btb_hit),
        .lookup_taken (btb_taken),
        .lookup_likely(btb_likely),
        .lookup_target(btb_target),
        .upd_valid    (Upd_Valid),
        .upd_pc       (Upd_PC),
        .upd_target   (Upd_Target),
        .upd_taken    (Upd_Taken),
        .upd_likely   (Upd_Likely)
    );

    logic pred_en;
    assign pred_en = (state_q == SEQ);

    // The delay slot itself is never predicted.
    assign IF_BTB_Hit       = pred_en && btb_hit;
    assign IF_Branch        = pred_en && btb_hit && btb_taken;
    assign IF_Branch_likely = pred_en && btb_hit && btb_likely;

    assign imem_addr      = pc_q;
    assign IF_PC          = pc_q;
    assign IF_PC_plus_4   = pc_q + 32'd4;
    assign IF_Instruction = imem_rdata;
    assign IF_Flush       = Redirect_Valid;

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        pend_target_d = pend_target_q;
        if (Redirect_Valid) begin
            pc_d          = Redirect_Target;
            state_d       = SEQ;
            pend_target_d = '0;
        end else if (!Stall) begin
            case (state_q)
                PEND: begin
                    pc_d    = pend_target_q;
                    state_d = SEQ;
                end
                default: begin
                    pc_d = IF_PC_plus_4;
                    if (IF_Branch) begin
                        pend_target_d = btb_target;
                        state_d       = PEND;
                    end
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            state_q       <= SEQ;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, BTB training and
// prediction, delay-slot sequencing with stall/redirect, counters, reset.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC  = 32'hBFC0_0000;
    localparam logic [31:0] IXOR = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Redirect_Valid, Upd_Valid, Upd_Taken, Upd_Likely;
    logic [31:0] Redirect_Target, Upd_PC, Upd_Target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_PC, IF_PC_plus_4, IF_Instruction;
    logic        IF_Branch, IF_Branch_likely, IF_BTB_Hit, IF_Flush;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ IXOR;

    if_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .Stall           (Stall),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .Upd_Valid       (Upd_Valid),
        .Upd_PC          (Upd_PC),
        .Upd_Target      (Upd_Target),
        .Upd_Taken       (Upd_Taken),
        .Upd_Likely      (Upd_Likely),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .IF_PC           (IF_PC),
        .IF_PC_plus_4    (IF_PC_plus_4),
        .IF_Instruction  (IF_Instruction),
        .IF_Branch       (IF_Branch),
        .IF_Branch_likely(IF_Branch_likely),
        .IF_BTB_Hit      (IF_BTB_Hit),
        .IF_Flush        (IF_Flush)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Stall = 1'b0; Redirect_Valid = 1'b0; Redirect_Target = '0;
        Upd_Valid = 1'b0; Upd_PC = '0; Upd_Target = '0; Upd_Taken = 1'b0; Upd_Likely = 1'b0;
        tick(); tick();
        n_checks++;
        if (IF_PC !== RPC) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", IF_PC, RPC); end
        n_checks++;
        if (IF_PC_plus_4 !== RPC + 32'd4) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=%h", IF_PC_plus_4, RPC + 32'd4); end
        n_checks++;
        if ({IF_Branch, IF_BTB_Hit, IF_Branch_likely} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pred got=%b exp=000", {IF_Branch, IF_BTB_Hit, IF_Branch_likely});
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            exp_pc = RPC + 32'(4 * i);
            n_checks++;
            if (IF_PC !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, IF_PC, exp_pc); end
            n_checks++;
            if (IF_PC_plus_4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, IF_PC_plus_4, exp_pc + 32'd4); end
            n_checks++;
            if (IF_Instruction !== (exp_pc ^ IXOR)) begin n_fail++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, IF_Instruction, exp_pc ^ IXOR); end
            n_checks++;
            if (IF_Branch !== 1'b0) begin n_fail++; $display("FAIL seq_branch[%0d] got=%b exp=0", i, IF_Branch); end
            if (i < 2) tick();
        end
    endtask

    // PC is at BFC0_0008 on entry.
    task automatic test_train_predict();
        Upd_Valid = 1'b1; Upd_PC = 32'hBFC0_0010; Upd_Target = 32'hBFC0_0100; Upd_Taken = 1'b1; Upd_Likely = 1'b0;
        tick();
        Upd_Valid = 1'b0;
        n_checks++;
        if (IF_PC !== 32'hBFC0_000C || IF_BTB_Hit !== 1'b0) begin
            n_fail++; $display("FAIL tp_000c got pc=%h hit=%b exp pc=bfc0000c hit=0", IF_PC, IF_BTB_Hit);
        end
        tick();
        n_checks++;
        if (IF_PC !== 32'hBFC0_0010 || IF_BTB_Hit !== 1'b1 || IF_Branch !== 1'b1) begin
            n_fail++; $display("FAIL tp_0010 got pc=%h hit=%b br=%b exp pc=bfc00010 hit=1 br=1", IF_PC, IF_BTB_Hit, IF_Branch);
        end
        tick();
        n_checks++;
        if (IF_PC !== 32'hBFC0_0014 || IF_Branch !== 1'b0) begin
            n_fail++; $display("FAIL tp_slot got pc=%h br=%b exp pc=bfc00014 br=0", IF_PC, IF_Branch);
        end
        tick();
        n_checks++;
        if (IF_PC !== 32'hBFC0_0100) begin n_fail++; $display("FAIL tp_target got=%h exp=bfc00100", IF_PC); end
    endtask

    task automatic test_stall_pend();
        Redirect_Valid = 1'b1; Redirect_Target = 32'hBFC0_0010;
        #1;
        n_checks++;
        if (IF_Flush !== 1'b1) begin n_fail++; $display("FAIL sp_flush got=%b exp=1", IF_Flush); end
        tick();
        Redirect_Valid = 1'b0;
        tick();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (IF_PC !== 32'hBFC0_0014 || IF_Branch !== 1'b0) begin
                n_fail++; $display("FAIL sp_hold[%0d] got pc=%h br=%b exp pc=bfc00014 br=0", i, IF_PC, IF_Branch);
            end
        end
        Stall = 1'b0;
        tick();
        n_checks++;
        if (IF_PC !== 32'hBFC0_0100) begin n_fail++; $display("FAIL sp_release got=%h exp=bfc00100", IF_PC); end
    endtask

    task automatic test_redirect_pend();
        Redirect_Valid = 1'b1; Redirect_Target = 32'hBFC0_0010;
        tick();
        Redirect_Valid = 1'b0;
        tick();
        n_checks++;
        if (IF_PC !== 32'hBFC0_0014) begin n_fail++; $display("FAIL rp_slot got=%h exp=bfc00014", IF_PC); end
        Stall = 1'b1; Redirect_Valid = 1'b1; Redirect_Target = 32'h8000_0180;
        #1;
        n_checks++;
        if (IF_Flush !== 1'b1) begin n_fail++; $display("FAIL rp_flush got=%b exp=1", IF_Flush); end
        tick();
        Stall = 1'b0; Redirect_Valid = 1'b0;
        n_checks++;
        if (IF_PC !== 32'h8000_0180) begin n_fail++; $display("FAIL rp_target got=%h exp=80000180", IF_PC); end
        tick();
        n_checks++;
        if (IF_PC !== 32'h8000_0184) begin n_fail++; $display("FAIL rp_no_pend got=%h exp=80000184", IF_PC); end
    endtask

    // Entry for BFC0_0010 holds ctr=10 on entry. Each step redirects to the
    // branch while training it, so the fetch sees the post-update counter.
    task automatic test_counter();
        logic       taken_v [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       likely_v[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_br  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            Redirect_Valid = 1'b1; Redirect_Target = 32'hBFC0_0010;
            Upd_Valid = 1'b1; Upd_PC = 32'hBFC0_0010; Upd_Target = 32'hBFC0_0100;
            Upd_Taken = taken_v[i]; Upd_Likely = likely_v[i];
            tick();
            Redirect_Valid = 1'b0; Upd_Valid = 1'b0;
            n_checks++;
            if (IF_BTB_Hit !== 1'b1 || IF_Branch !== exp_br[i] || IF_Branch_likely !== likely_v[i]) begin
                n_fail++;
                $display("FAIL ctr_step[%0d] got hit=%b br=%b lk=%b exp hit=1 br=%b lk=%b",
                         i, IF_BTB_Hit, IF_Branch, IF_Branch_likely, exp_br[i], likely_v[i]);
            end
        end
        // Same-cycle update must not affect the current lookup (ctr 10 -> 01).
        Upd_Valid = 1'b1; Upd_Taken = 1'b0;
        #1;
        n_checks++;
        if (IF_Branch !== 1'b1) begin n_fail++; $display("FAIL ctr_preupdate got=%b exp=1", IF_Branch); end
        tick();
        Upd_Valid = 1'b0;
        n_checks++;
        if (IF_PC !== 32'hBFC0_0014) begin n_fail++; $display("FAIL ctr_slot got=%h exp=bfc00014", IF_PC); end
        // Miss and not taken allocates nothing.
        Upd_Valid = 1'b1; Upd_PC = 32'hBFC0_0020; Upd_Taken = 1'b0;
        tick();
        Upd_Valid = 1'b0;
        Redirect_Valid = 1'b1; Redirect_Target = 32'hBFC0_0020;
        tick();
        Redirect_Valid = 1'b0;
        n_checks++;
        if (IF_BTB_Hit !== 1'b0) begin n_fail++; $display("FAIL ctr_nt_miss got=%b exp=0", IF_BTB_Hit); end
    endtask

    task automatic test_wrap();
        Redirect_Valid = 1'b1; Redirect_Target = 32'hFFFF_FFFC;
        tick();
        Redirect_Valid = 1'b0;
        n_checks++;
        if (IF_PC_plus_4 !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=00000000", IF_PC_plus_4); end
        tick();
        n_checks++;
        if (IF_PC !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc got=%h exp=00000000", IF_PC); end
    endtask

    // Entry for BFC0_0010 holds ctr=01 on entry; one taken update makes it 10.
    task automatic test_reset_mid_pend();
        Redirect_Valid = 1'b1; Redirect_Target = 32'hBFC0_0010;
        Upd_Valid = 1'b1; Upd_PC = 32'hBFC0_0010; Upd_Taken = 1'b1; Upd_Likely = 1'b0;
        tick();
        Redirect_Valid = 1'b0; Upd_Valid = 1'b0;
        n_checks++;
        if (IF_Branch !== 1'b1) begin n_fail++; $display("FAIL rst_pre_branch got=%b exp=1", IF_Branch); end
        tick();
        n_checks++;
        if (IF_PC !== 32'hBFC0_0014) begin n_fail++; $display("FAIL rst_pre_slot got=%h exp=bfc00014", IF_PC); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (IF_PC !== RPC) begin n_fail++; $display("FAIL rst_async_pc got=%h exp=%h", IF_PC, RPC); end
        tick();
        reset = 1'b0;
        Redirect_Valid = 1'b1; Redirect_Target = 32'hBFC0_0010;
        tick();
        Redirect_Valid = 1'b0;
        n_checks++;
        if (IF_BTB_Hit !== 1'b0 || IF_Branch !== 1'b0) begin
            n_fail++; $display("FAIL rst_btb_clear got hit=%b br=%b exp hit=0 br=0", IF_BTB_Hit, IF_Branch);
        end
        tick();
        n_checks++;
        if (IF_PC !== 32'hBFC0_0014) begin n_fail++; $display("FAIL rst_no_pend got=%h exp=bfc00014", IF_PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_train_predict();
        test_stall_pend();
        test_redirect_pend();
        test_counter();
        test_wrap();
        test_reset_mid_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
